rr_mux_arb: RTL and testbench



---
 rtl/rr_mux_arb.sv | 97 +++++++++
 tb/tb_rr_mux_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with an internal round-robin / fixed-priority
// arbiter feeding a one-entry valid/ready output register.
module rr_mux_arb #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             load;
    logic             found;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;

    always_comb begin
        load  = !out_valid_q || out_ready;
        found = 1'b0;
        grant = '0;
        // First pass covers ptr..N_CH-1 (or everything in fixed priority);
        // the second pass supplies the wrap-around to 0..ptr-1.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && in_valid[i] && (mode || i >= 32'(ptr_q))) begin
                found = 1'b1;
                grant = SEL_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && in_valid[i]) begin
                found = 1'b1;
                grant = SEL_W'(i);
            end
        end

        grant_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == grant) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end

        in_ready = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n && load && found && (SEL_W'(i) == grant);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_data_d = grant_data;
                out_sel_d  = grant;
                if (!mode) begin
                    ptr_d = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: a 4-channel and a 3-channel instance,
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        out_ready;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          pa, pb;
    logic        ova, ovb;
    logic [7:0]  oda, odb;
    int          osa, osb;

    rr_mux_arb #(.N_CH(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_mux_arb #(.N_CH(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Channel chosen by scanning from the priority start position, modulo n.
    function automatic int grant_of(int n, int ptr, logic md, logic [7:0] v);
        for (int off = 0; off < n; off++) begin
            int c;
            c = md ? off : (ptr + off) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        pa = 0; pb = 0; ova = 1'b0; ovb = 1'b0;
        oda = '0; odb = '0; osa = 0; osb = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic la, lb;
        int   ga, gb;
        #1;
        la = !ova || out_ready;
        lb = !ovb || out_ready;
        ga = (rst_n && la) ? grant_of(4, pa, mode, {4'b0, in_valid})  : -1;
        gb = (rst_n && lb) ? grant_of(3, pb, mode, {5'b0, in_valid3}) : -1;
        check("a_ready", 32'(in_ready),  (ga >= 0) ? (32'd1 << ga) : 32'd0);
        check("a_valid", 32'(out_valid), 32'(ova));
        check("a_data",  32'(out_data),  32'(oda));
        check("a_sel",   32'(out_sel),   32'(osa));
        check("b_ready", 32'(in_ready3), (gb >= 0) ? (32'd1 << gb) : 32'd0);
        check("b_valid", 32'(out_valid3), 32'(ovb));
        check("b_data",  32'(out_data3), 32'(odb));
        check("b_sel",   32'(out_sel3),  32'(osb));
        @(posedge clk);
        if (rst_n) begin
            if (la) begin
                if (ga >= 0) begin
                    ova = 1'b1; oda = in_data[8*ga +: 8]; osa = ga;
                    if (!mode) pa = (ga + 1) % 4;
                end else ova = 1'b0;
            end
            if (lb) begin
                if (gb >= 0) begin
                    ovb = 1'b1; odb = in_data3[8*gb +: 8]; osb = gb;
                    if (!mode) pb = (gb + 1) % 3;
                end else ovb = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_a_valid", 32'(out_valid),  32'd0);
        check("arst_a_data",  32'(out_data),   32'd0);
        check("arst_a_ready", 32'(in_ready),   32'd0);
        check("arst_b_valid", 32'(out_valid3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid3 = 3'b111;
        in_data3  = {8'hC3, 8'hB2, 8'hA1};
        model_reset();

        // held in reset with all channels requesting
        step();
        step();
        rst_n = 1'b1;

        // round-robin fairness on both instances, first grant is channel 0
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_sel",  32'(out_sel),  32'(k % 4));
            check("rr_data", 32'(out_data), 32'(8'h11 * (k % 4 + 1)));
            check("n3_sel",  32'(out_sel3), 32'(k % 3));
        end

        // sparse requests with wrap: force ptr to 3, then 0101 grants 0 then 2
        in_valid3 = 3'($urandom);
        in_valid  = 4'b0100;
        step();
        check("sparse_set", 32'(out_sel), 32'd2);
        in_valid  = 4'b0101;
        step();
        check("sparse_wrap", 32'(out_sel), 32'd0);
        step();
        check("sparse_next", 32'(out_sel), 32'd2);

        // fixed priority leaves the pointer (3) untouched
        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("fixed_sel", 32'(out_sel), 32'd1);
        end
        mode     = 1'b0;
        in_valid = 4'hF;
        step();
        check("resume_ptr", 32'(out_sel), 32'd3);

        // backpressure: register holds, no grants
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_sel",   32'(out_sel),   32'd3);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_sel",   32'(out_sel),   32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd1);

        // randomized traffic with occasional mode flips and async resets
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
            in_valid3 = ($urandom_range(0, 4) == 0) ? 3'b0 : 3'($urandom);
            in_data   = $urandom;
            in_data3  = 24'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step();
            if (cyc % 97 == 50) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
